// File: rtl/tt_sweeper_pkg.sv
// Shared definitions for the exhaustive-stimulus sweeper: FSM state encoding
// and the default MISR polynomial/seed constants.
package tt_sweeper_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [15:0] DEFAULT_POLY = 16'h1021;
   localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;
endpackage

// File: rtl/tt_sweeper_misr.sv
// Multiple-input signature register: shift left, fold the MSB back through POLY,
// and XOR in the parallel response word.
module misr #(
   parameter int                SIG_W = 16,
   parameter logic [SIG_W-1:0]  POLY  = SIG_W'(16'h1021),
   parameter logic [SIG_W-1:0]  SEED  = {SIG_W{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [SIG_W-1:0] din,
   output logic [SIG_W-1:0] sig
);
   always_ff @(posedge clk) begin
      if (rst) begin
         sig <= SEED;
      end else if (load) begin
         sig <= SEED;
      end else if (en) begin
         sig <= (sig << 1) ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
      end
   end
endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive-stimulus engine: walks all 2^N_IN input vectors in ascending order,
// holds each HOLD cycles, and compacts the sampled response into a MISR signature.
module tt_sweeper
   import tt_sweeper_pkg::*;
#(
   parameter int               N_IN  = 4,
   parameter int               N_OUT = 3,
   parameter int               HOLD  = 1,
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
   parameter logic [SIG_W-1:0] SEED  = {SIG_W{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             loop,
   input  logic [N_OUT-1:0] resp,
   output logic [N_IN-1:0]  pattern,
   output logic             sample,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature
);
   localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
   localparam logic [N_IN-1:0] PAT_LAST  = '1;
   localparam logic            FIRST_SAMPLE = (HOLD == 1);

   state_t          state_reg;
   logic [N_IN-1:0] pattern_reg;
   logic [HW-1:0]   hold_reg;
   logic            sample_reg;
   logic            busy_reg;
   logic            done_reg;
   logic            loop_reg;

   logic capture;
   logic misr_load;

   // An abort on the capture edge discards that vector's response.
   assign capture   = (state_reg == ST_APPLY) && (hold_reg == HOLD_LAST) && !abort;
   assign misr_load = !abort && (((state_reg == ST_IDLE) && start) ||
                                 ((state_reg == ST_DONE) && loop_reg));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         pattern_reg <= '0;
         hold_reg    <= '0;
         sample_reg  <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         loop_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               pattern_reg <= '0;
               hold_reg    <= '0;
               done_reg    <= 1'b0;
               sample_reg  <= 1'b0;
               busy_reg    <= 1'b0;
               if (start && !abort) begin
                  state_reg  <= ST_APPLY;
                  busy_reg   <= 1'b1;
                  sample_reg <= FIRST_SAMPLE;
               end
            end
            ST_APPLY: begin
               if (abort) begin
                  state_reg   <= ST_IDLE;
                  pattern_reg <= '0;
                  hold_reg    <= '0;
                  busy_reg    <= 1'b0;
                  sample_reg  <= 1'b0;
               end else if (hold_reg == HOLD_LAST) begin
                  hold_reg <= '0;
                  if (pattern_reg == PAT_LAST) begin
                     // Terminal vector: the pattern stays all-ones through DONE.
                     state_reg  <= ST_DONE;
                     busy_reg   <= 1'b0;
                     sample_reg <= 1'b0;
                     done_reg   <= 1'b1;
                     loop_reg   <= loop;
                  end else begin
                     pattern_reg <= pattern_reg + N_IN'(1);
                     sample_reg  <= FIRST_SAMPLE;
                  end
               end else begin
                  hold_reg   <= hold_reg + HW'(1);
                  sample_reg <= ((hold_reg + HW'(1)) == HOLD_LAST);
               end
            end
            ST_DONE: begin
               done_reg    <= 1'b0;
               pattern_reg <= '0;
               hold_reg    <= '0;
               if (!abort && loop_reg) begin
                  state_reg  <= ST_APPLY;
                  busy_reg   <= 1'b1;
                  sample_reg <= FIRST_SAMPLE;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg   <= ST_IDLE;
               pattern_reg <= '0;
               hold_reg    <= '0;
               sample_reg  <= 1'b0;
               busy_reg    <= 1'b0;
               done_reg    <= 1'b0;
            end
         endcase
      end
   end

   misr #(
      .SIG_W (SIG_W),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (misr_load),
      .en   (capture),
      .din  (SIG_W'(resp)),
      .sig  (signature)
   );

   assign pattern = pattern_reg;
   assign sample  = sample_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
endmodule

// File: tb/tb_tt_sweeper.sv
// Bench for tt_sweeper: four parameterisations, scoreboarded patterns and signatures.
module tb_tt_sweeper;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start_a, start_b, start_c, start_d, abort, loop, const_mode;
   logic zero;
   assign zero = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_pat_q[$];
   logic [15:0] exp_sig_q[$];

   // DUT A: tiny sweep, resp = pattern[0]
   logic [1:0] pattern_a; logic sample_a, busy_a, done_a; logic [3:0] sig_a; logic resp_a;
   assign resp_a = pattern_a[0];
   tt_sweeper #(.N_IN(2), .N_OUT(1), .HOLD(1), .SIG_W(4), .POLY(4'h3), .SEED(4'h0)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(zero), .loop(zero), .resp(resp_a),
      .pattern(pattern_a), .sample(sample_a), .busy(busy_a), .done(done_a), .signature(sig_a));

   // DUT B: resp tied low, seed 8
   logic [1:0] pattern_b; logic sample_b, busy_b, done_b; logic [3:0] sig_b; logic resp_b;
   assign resp_b = 1'b0;
   tt_sweeper #(.N_IN(2), .N_OUT(1), .HOLD(1), .SIG_W(4), .POLY(4'h3), .SEED(4'h8)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(zero), .loop(zero), .resp(resp_b),
      .pattern(pattern_b), .sample(sample_b), .busy(busy_b), .done(done_b), .signature(sig_b));

   // DUT C: HOLD=3
   logic [1:0] pattern_c; logic sample_c, busy_c, done_c; logic [15:0] sig_c; logic [2:0] resp_c;
   assign resp_c = {pattern_c[1], ~pattern_c[0], ^pattern_c};
   tt_sweeper #(.N_IN(2), .HOLD(3)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .abort(zero), .loop(zero), .resp(resp_c),
      .pattern(pattern_c), .sample(sample_c), .busy(busy_c), .done(done_c), .signature(sig_c));

   // DUT D: all defaults
   logic [3:0] pattern_d; logic sample_d, busy_d, done_d; logic [15:0] sig_d; logic [2:0] resp_d;
   function automatic logic [2:0] resp_fn(input logic [3:0] p);
      return {p[3] ^ p[0], p[2] & p[1], p[1] | p[3]};
   endfunction
   assign resp_d = const_mode ? 3'b101 : resp_fn(pattern_d);
   tt_sweeper dut_d (
      .clk(clk), .rst(rst), .start(start_d), .abort(abort), .loop(loop), .resp(resp_d),
      .pattern(pattern_d), .sample(sample_d), .busy(busy_d), .done(done_d), .signature(sig_d));

   function automatic logic [15:0] mstep(input logic [15:0] s, input logic [15:0] r,
                                         input int w, input logic [15:0] poly);
      logic [15:0] mask;
      logic [15:0] n;
      mask = 16'((17'd1 << w) - 17'd1);
      n = (s << 1) ^ (s[w-1] ? poly : 16'h0) ^ r;
      return n & mask;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_a = 0; start_b = 0; start_c = 0; start_d = 0;
      abort = 0; loop = 0; const_mode = 0;
      tick(); tick();
      checks++;
      if ({pattern_a, sample_a, busy_a, done_a, sig_a} !== {2'd0, 3'b000, 4'h0}) begin
         failures++; $display("FAIL reset_a got=%h required=%h", {pattern_a, sample_a, busy_a, done_a, sig_a}, 9'h0);
      end
      checks++;
      if ({pattern_b, sample_b, busy_b, done_b, sig_b} !== {2'd0, 3'b000, 4'h8}) begin
         failures++; $display("FAIL reset_b got=%h required=%h", {pattern_b, sample_b, busy_b, done_b, sig_b}, 9'h8);
      end
      checks++;
      if ({pattern_c, sample_c, busy_c, done_c, sig_c} !== {2'd0, 3'b000, 16'hFFFF}) begin
         failures++; $display("FAIL reset_c got=%h", {pattern_c, sample_c, busy_c, done_c, sig_c});
      end
      checks++;
      if ({pattern_d, sample_d, busy_d, done_d, sig_d} !== {4'd0, 3'b000, 16'hFFFF}) begin
         failures++; $display("FAIL reset_d got=%h", {pattern_d, sample_d, busy_d, done_d, sig_d});
      end
      rst = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_sweep_a();
      logic eb, ed;
      logic [15:0] e;
      exp_pat_q.delete(); exp_sig_q.delete();
      for (int i = 0; i < 4; i++) exp_pat_q.push_back(16'(i));
      exp_sig_q.push_back(16'h5);
      start_a = 1; tick(); start_a = 0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         eb = (cyc <= 4); ed = (cyc == 5);
         checks++;
         if ({busy_a, sample_a, done_a} !== {eb, eb, ed}) begin
            failures++; $display("FAIL sweep_a_ctl cyc=%0d got=%b required=%b", cyc, {busy_a, sample_a, done_a}, {eb, eb, ed});
         end
         if (sample_a) begin
            checks++;
            if (exp_pat_q.size() == 0) begin
               failures++; $display("FAIL sweep_a_extra_sample cyc=%0d got=1 required=0", cyc);
            end else begin
               e = exp_pat_q.pop_front();
               if (16'(pattern_a) !== e) begin
                  failures++; $display("FAIL sweep_a_pattern cyc=%0d got=%0d required=%0d", cyc, pattern_a, e);
               end
            end
         end
         if (done_a) begin
            checks++;
            if (exp_sig_q.size() == 0) begin
               failures++; $display("FAIL sweep_a_extra_done cyc=%0d", cyc);
            end else begin
               e = exp_sig_q.pop_front();
               if (16'(sig_a) !== e) begin
                  failures++; $display("FAIL sweep_a_sig got=%h required=%h", sig_a, e);
               end
            end
         end
         tick();
      end
      checks++;
      if (exp_pat_q.size() + exp_sig_q.size() != 0) begin
         failures++; $display("FAIL sweep_a_leftover got=%0d required=0", exp_pat_q.size() + exp_sig_q.size());
      end
      $display("test_sweep_a done");
   endtask

   task automatic test_zero_resp_b();
      logic eb, ed;
      logic [15:0] e;
      exp_pat_q.delete(); exp_sig_q.delete();
      for (int i = 0; i < 4; i++) exp_pat_q.push_back(16'(i));
      exp_sig_q.push_back(16'hB);
      start_b = 1; tick(); start_b = 0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         eb = (cyc <= 4); ed = (cyc == 5);
         checks++;
         if ({busy_b, sample_b, done_b} !== {eb, eb, ed}) begin
            failures++; $display("FAIL zero_b_ctl cyc=%0d got=%b required=%b", cyc, {busy_b, sample_b, done_b}, {eb, eb, ed});
         end
         if (sample_b && exp_pat_q.size() != 0) begin
            e = exp_pat_q.pop_front();
            checks++;
            if (16'(pattern_b) !== e) begin
               failures++; $display("FAIL zero_b_pattern cyc=%0d got=%0d required=%0d", cyc, pattern_b, e);
            end
         end
         if (done_b && exp_sig_q.size() != 0) begin
            e = exp_sig_q.pop_front();
            checks++;
            if (16'(sig_b) !== e) begin
               failures++; $display("FAIL zero_b_sig got=%h required=%h", sig_b, e);
            end
         end
         tick();
      end
      checks++;
      if (exp_pat_q.size() + exp_sig_q.size() != 0) begin
         failures++; $display("FAIL zero_b_leftover got=%0d required=0", exp_pat_q.size() + exp_sig_q.size());
      end
      $display("test_zero_resp_b done");
   endtask

   task automatic test_hold_c();
      logic eb, es, ed;
      logic [1:0] ep;
      logic [15:0] s, e;
      logic [1:0] p;
      exp_pat_q.delete(); exp_sig_q.delete();
      s = 16'hFFFF;
      for (int i = 0; i < 4; i++) begin
         p = 2'(i);
         exp_pat_q.push_back(16'(i));
         s = mstep(s, 16'({p[1], ~p[0], ^p}), 16, 16'h1021);
      end
      exp_sig_q.push_back(s);
      start_c = 1; tick(); start_c = 0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         eb = (cyc <= 12); es = (cyc <= 12) && (cyc % 3 == 0); ed = (cyc == 13);
         ep = (cyc <= 12) ? 2'((cyc - 1) / 3) : (cyc == 13 ? 2'd3 : 2'd0);
         checks++;
         if ({busy_c, sample_c, done_c, pattern_c} !== {eb, es, ed, ep}) begin
            failures++; $display("FAIL hold_c cyc=%0d got=%b required=%b", cyc, {busy_c, sample_c, done_c, pattern_c}, {eb, es, ed, ep});
         end
         if (sample_c && exp_pat_q.size() != 0) begin
            e = exp_pat_q.pop_front();
            checks++;
            if (16'(pattern_c) !== e) begin
               failures++; $display("FAIL hold_c_pattern cyc=%0d got=%0d required=%0d", cyc, pattern_c, e);
            end
         end
         if (done_c && exp_sig_q.size() != 0) begin
            e = exp_sig_q.pop_front();
            checks++;
            if (sig_c !== e) begin
               failures++; $display("FAIL hold_c_sig got=%h required=%h", sig_c, e);
            end
         end
         tick();
      end
      checks++;
      if (exp_pat_q.size() + exp_sig_q.size() != 0) begin
         failures++; $display("FAIL hold_c_leftover got=%0d required=0", exp_pat_q.size() + exp_sig_q.size());
      end
      $display("test_hold_c done");
   endtask

   task automatic test_abort_d();
      logic eb, ed;
      logic [15:0] s, e;
      const_mode = 0; loop = 0;
      start_d = 1; tick(); start_d = 0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         checks++;
         if ({busy_d, pattern_d} !== {1'b1, 4'(cyc - 1)}) begin
            failures++; $display("FAIL abort_pre cyc=%0d got=%b required=%b", cyc, {busy_d, pattern_d}, {1'b1, 4'(cyc - 1)});
         end
         if (cyc < 6) tick();
      end
      abort = 1; tick(); abort = 0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({pattern_d, busy_d, done_d, sample_d} !== 7'd0) begin
            failures++; $display("FAIL abort_idle k=%0d got=%b required=0000000", k, {pattern_d, busy_d, done_d, sample_d});
         end
         if (k < 2) tick();
      end
      exp_pat_q.delete(); exp_sig_q.delete();
      s = 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
         exp_pat_q.push_back(16'(i));
         s = mstep(s, 16'(resp_fn(4'(i))), 16, 16'h1021);
      end
      exp_sig_q.push_back(s);
      start_d = 1; tick(); start_d = 0;
      checks++;
      if (sig_d !== 16'hFFFF) begin
         failures++; $display("FAIL abort_reseed got=%h required=ffff", sig_d);
      end
      for (int cyc = 1; cyc <= 18; cyc++) begin
         eb = (cyc <= 16); ed = (cyc == 17);
         checks++;
         if ({busy_d, sample_d, done_d} !== {eb, eb, ed}) begin
            failures++; $display("FAIL abort_rerun_ctl cyc=%0d got=%b required=%b", cyc, {busy_d, sample_d, done_d}, {eb, eb, ed});
         end
         if (sample_d && exp_pat_q.size() != 0) begin
            e = exp_pat_q.pop_front();
            checks++;
            if (16'(pattern_d) !== e) begin
               failures++; $display("FAIL abort_rerun_pattern cyc=%0d got=%0d required=%0d", cyc, pattern_d, e);
            end
         end
         if (done_d && exp_sig_q.size() != 0) begin
            e = exp_sig_q.pop_front();
            checks++;
            if (sig_d !== e) begin
               failures++; $display("FAIL abort_rerun_sig got=%h required=%h", sig_d, e);
            end
         end
         tick();
      end
      checks++;
      if (exp_pat_q.size() + exp_sig_q.size() != 0) begin
         failures++; $display("FAIL abort_rerun_leftover got=%0d required=0", exp_pat_q.size() + exp_sig_q.size());
      end
      $display("test_abort_d done");
   endtask

   task automatic test_loop_d();
      logic [15:0] s, e;
      int done_cyc[$];
      exp_sig_q.delete();
      const_mode = 1; loop = 1;
      s = 16'hFFFF;
      for (int i = 0; i < 16; i++) s = mstep(s, 16'h5, 16, 16'h1021);
      exp_sig_q.push_back(s);
      exp_sig_q.push_back(s);
      start_d = 1; tick(); start_d = 0;
      for (int cyc = 1; cyc <= 50; cyc++) begin
         if (done_d) begin
            done_cyc.push_back(cyc);
            checks++;
            if (exp_sig_q.size() == 0) begin
               failures++; $display("FAIL loop_extra_done cyc=%0d", cyc);
            end else begin
               e = exp_sig_q.pop_front();
               if (sig_d !== e || busy_d !== 1'b0) begin
                  failures++; $display("FAIL loop_done_sig cyc=%0d got=%h/%b required=%h/0", cyc, sig_d, busy_d, e);
               end
            end
         end
         start_d = (cyc == 8);
         if (cyc == 20) loop = 0;
         tick();
      end
      start_d = 0;
      checks++;
      if (done_cyc.size() != 2) begin
         failures++; $display("FAIL loop_done_count got=%0d required=2", done_cyc.size());
      end else begin
         checks++;
         if (done_cyc[1] - done_cyc[0] != 17 || done_cyc[0] != 17) begin
            failures++; $display("FAIL loop_done_spacing got=%0d,%0d required=17,34", done_cyc[0], done_cyc[1]);
         end
      end
      checks++;
      if (busy_d !== 1'b0) begin
         failures++; $display("FAIL loop_stop got=%b required=0", busy_d);
      end
      const_mode = 0;
      $display("test_loop_d done");
   endtask

   task automatic test_rst_d();
      start_d = 1; tick(); start_d = 0;
      for (int k = 0; k < 5; k++) tick();
      rst = 1; start_d = 1; tick();
      checks++;
      if ({pattern_d, busy_d, done_d, sample_d, sig_d} !== {4'd0, 3'b000, 16'hFFFF}) begin
         failures++; $display("FAIL rst_mid got=%h required=%h", {pattern_d, busy_d, done_d, sample_d, sig_d}, {4'd0, 3'b000, 16'hFFFF});
      end
      rst = 0; tick();
      checks++;
      if ({busy_d, pattern_d, sample_d} !== {1'b1, 4'd0, 1'b1}) begin
         failures++; $display("FAIL rst_restart got=%b required=1_0000_1", {busy_d, pattern_d, sample_d});
      end
      start_d = 0; abort = 1; tick(); abort = 0;
      checks++;
      if ({busy_d, pattern_d} !== 5'd0) begin
         failures++; $display("FAIL rst_cleanup got=%b required=00000", {busy_d, pattern_d});
      end
      $display("test_rst_d done");
   endtask

   initial begin
      test_reset();
      test_sweep_a();
      test_zero_resp_b();
      test_hold_c();
      test_abort_d();
      test_loop_d();
      test_rst_d();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
